// File: rtl/uart_rx_fifo_p.sv
// UART receive channel: runtime baud divisor, 16x oversampling, 5-8 data bits,
// optional parity, 1/2 stop bits, FWFT FIFO with per-character error flags.
module uart_rx_fifo_p #(
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned OVS        = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       data_len,
  input  logic [1:0]       prty_sel,
  input  logic             stop_sel,
  input  logic             rx_in,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [7:0]       rd_data,
  output logic             rd_err_prty,
  output logic             rd_err_frame,
  output logic [CNT_W-1:0] fifo_count,
  output logic             overflow,
  input  logic             clr_ovf,
  output logic             break_det
);

  localparam int unsigned TC_W = $clog2(OVS);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam logic [TC_W-1:0]  TC_HALF = TC_W'(OVS / 2 - 1);
  localparam logic [TC_W-1:0]  TC_LAST = TC_W'(OVS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  state_t state, state_n;

  logic             sync1, rxs, rxs_q;
  logic [DIV_W-1:0] div_cnt, div_lat;
  logic [TC_W-1:0]  tc;
  logic [2:0]       bc;
  logic [1:0]       len_l, prty_l;
  logic             stop_l;
  logic [7:0]       data_r;
  logic             par_bit, ef, wait_high;
  logic             push_pend, brk_pend;
  logic [9:0]       push_word;

  logic tick, start_det, sample, last_bit, par_en, par_odd, finish, ef_n, pe_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_q <= 1'b1;
    end else begin
      sync1 <= rx_in;
      rxs   <= sync1;
      rxs_q <= rxs;
    end
  end

  assign start_det = (state == IDLE) && !wait_high && rxs_q && !rxs;
  assign tick      = (state != IDLE) && (div_cnt == div_lat);
  assign par_en    = (prty_l == 2'b01) || (prty_l == 2'b10);
  assign par_odd   = (prty_l == 2'b01);
  assign sample    = tick && (tc == ((state == START) ? TC_HALF : TC_LAST));
  assign last_bit  = (bc == ({1'b0, len_l} + 3'd4));
  assign ef_n      = ef | !rxs;
  assign pe_n      = par_en && ((^data_r ^ par_bit) != par_odd);

  // Divisor is re-latched only at wrap so a baud_div change never truncates a tick period
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      div_lat <= '0;
    end else if (state == IDLE || tick) begin
      div_cnt <= '0;
      div_lat <= baud_div;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_comb begin
    state_n = state;
    finish  = 1'b0;
    case (state)
      IDLE:   if (start_det) state_n = START;
      START:  if (sample) state_n = rxs ? IDLE : DATA;
      DATA:   if (sample && last_bit) state_n = par_en ? PARITY : STOP1;
      PARITY: if (sample) state_n = STOP1;
      STOP1:
        if (sample) begin
          if (stop_l) begin
            state_n = STOP2;
          end else begin
            state_n = IDLE;
            finish  = 1'b1;
          end
        end
      STOP2:
        if (sample) begin
          state_n = IDLE;
          finish  = 1'b1;
        end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tc        <= '0;
      bc        <= '0;
      len_l     <= '0;
      prty_l    <= '0;
      stop_l    <= 1'b0;
      data_r    <= '0;
      par_bit   <= 1'b0;
      ef        <= 1'b0;
      wait_high <= 1'b0;
      push_pend <= 1'b0;
      brk_pend  <= 1'b0;
      push_word <= '0;
    end else begin
      state     <= state_n;
      push_pend <= finish;
      brk_pend  <= finish && (data_r == 8'h00) && ef_n && !par_bit;
      if (start_det) begin
        len_l   <= data_len;
        prty_l  <= prty_sel;
        stop_l  <= stop_sel;
        tc      <= '0;
        bc      <= '0;
        data_r  <= '0;
        par_bit <= 1'b0;
        ef      <= 1'b0;
      end else if (tick) begin
        // Restarting tc at the start-bit midpoint puts every later sample mid-bit
        tc <= sample ? '0 : tc + TC_W'(1);
      end
      if (sample) begin
        case (state)
          DATA: begin
            data_r[bc] <= rxs;
            bc         <= bc + 3'd1;
          end
          PARITY: par_bit <= rxs;
          STOP1, STOP2: if (!rxs) ef <= 1'b1;
          default: ;
        endcase
      end
      if (finish) begin
        push_word <= {ef_n, pe_n, data_r};
        wait_high <= ef_n;
      end else if (state == IDLE && rxs) begin
        wait_high <= 1'b0;
      end
    end
  end

  logic [9:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             pop, full, push_ok, drop;
  logic [9:0]       head;

  assign rd_valid = (count != '0);
  assign pop      = rd_valid && rd_ready;
  assign full     = (count == CNT_FULL);
  assign push_ok  = push_pend && (!full || pop);
  assign drop     = push_pend && full && !pop;
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  assign fifo_count   = count;
  assign rd_data      = rd_valid ? head[7:0] : 8'h00;
  assign rd_err_prty  = rd_valid && head[8];
  assign rd_err_frame = rd_valid && head[9];
  assign break_det    = brk_pend;

endmodule
